conv1d_stream_feeder: RTL



---
 rtl/conv1d_stream_feeder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/conv1d_stream_feeder.sv
// Producer for the FP16 1-D systolic convolution array: loads filter taps from SRAM,
// pulses the array reset, streams one input row into the A input, then flushes with zeros.
module conv1d_stream_feeder #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned MAX_TAPS     = 5,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            filter_size,
  input  logic [2:0]            stride,
  input  logic [ADDR_WIDTH-1:0] row_len,
  input  logic [ADDR_WIDTH-1:0] row_base,
  input  logic [ADDR_WIDTH-1:0] w_base,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] current_a,
  output logic                  a_valid,
  output logic [DATA_WIDTH-1:0] current_b1,
  output logic [DATA_WIDTH-1:0] current_b2,
  output logic [DATA_WIDTH-1:0] current_b3,
  output logic [DATA_WIDTH-1:0] current_b4,
  output logic [DATA_WIDTH-1:0] current_b5,
  output logic                  array_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [ADDR_WIDTH-1:0] out_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_ARR_RST, S_STREAM, S_DRAIN, S_FIN
  } state_t;

  state_t                  r_state, w_nxt_state;
  logic [ADDR_WIDTH-1:0]   r_cnt, w_nxt_cnt, w_cnt_inc;
  logic [ADDR_WIDTH-1:0]   r_row_len, r_row_base, r_w_base;
  logic [2:0]              r_fs;
  logic                    r_rd_en, w_nxt_rd_en;
  logic [ADDR_WIDTH-1:0]   r_rd_addr, w_nxt_rd_addr;
  logic                    r_wcap_en, r_ra_en;
  logic [2:0]              r_wcap_idx;
  logic [DATA_WIDTH-1:0]   r_tap [MAX_TAPS];
  logic [DATA_WIDTH-1:0]   r_cur_a;
  logic                    r_a_valid, r_arr_rst_n, r_busy, r_done, r_cfg_err;
  logic [ADDR_WIDTH-1:0]   r_out_count;
  logic                    w_legal, w_accept, w_reject;
  logic [ADDR_WIDTH-1:0]   w_span, w_div, w_out_count;

  // Command legality and window count, evaluated against the raw inputs in IDLE
  assign w_legal = (filter_size != 3'd0) && (filter_size <= 3'(MAX_TAPS)) &&
                   (stride != 3'd0) && (stride <= filter_size) &&
                   (row_len >= ADDR_WIDTH'(filter_size));
  assign w_accept    = (r_state == S_IDLE) && start && w_legal;
  assign w_reject    = (r_state == S_IDLE) && start && !w_legal;
  assign w_span      = row_len - ADDR_WIDTH'(filter_size);
  assign w_div       = (stride == 3'd0) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(stride);
  assign w_out_count = (w_span / w_div) + ADDR_WIDTH'(1);
  assign w_cnt_inc   = r_cnt + ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nxt_state;
  end

  // Next state plus the read issue for the coming cycle, so mem_rd_en is a plain register
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_rd_en   = 1'b0;
    w_nxt_rd_addr = r_rd_addr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt_state   = S_LOAD_W;
          w_nxt_cnt     = '0;
          w_nxt_rd_en   = 1'b1;
          w_nxt_rd_addr = w_base;
        end
      end
      S_LOAD_W: begin
        if (r_cnt == ADDR_WIDTH'(r_fs)) begin
          w_nxt_state = S_ARR_RST;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = w_cnt_inc;
          if (w_cnt_inc < ADDR_WIDTH'(r_fs)) begin
            w_nxt_rd_en   = 1'b1;
            w_nxt_rd_addr = r_w_base + w_cnt_inc;
          end
        end
      end
      S_ARR_RST: begin
        w_nxt_state   = S_STREAM;
        w_nxt_cnt     = '0;
        w_nxt_rd_en   = 1'b1;
        w_nxt_rd_addr = r_row_base;
      end
      S_STREAM: begin
        if (r_cnt == r_row_len - ADDR_WIDTH'(1)) begin
          w_nxt_state = S_DRAIN;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt     = w_cnt_inc;
          w_nxt_rd_en   = 1'b1;
          w_nxt_rd_addr = r_row_base + w_cnt_inc;
        end
      end
      S_DRAIN: begin
        if (r_cnt == ADDR_WIDTH'(DRAIN_CYCLES - 1)) begin
          w_nxt_state = S_FIN;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = w_cnt_inc;
        end
      end
      S_FIN:   w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_row_len   <= '0;
      r_row_base  <= '0;
      r_w_base    <= '0;
      r_fs        <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wcap_en   <= 1'b0;
      r_wcap_idx  <= '0;
      r_ra_en     <= 1'b0;
      r_cur_a     <= '0;
      r_a_valid   <= 1'b0;
      r_arr_rst_n <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_out_count <= '0;
      for (int unsigned k = 0; k < MAX_TAPS; k++) r_tap[k] <= '0;
    end else begin
      r_cnt       <= w_nxt_cnt;
      r_rd_en     <= w_nxt_rd_en;
      r_rd_addr   <= w_nxt_rd_addr;
      r_arr_rst_n <= (w_nxt_state != S_ARR_RST);
      r_busy      <= (w_nxt_state != S_IDLE);
      r_done      <= (w_nxt_state == S_FIN);
      r_cfg_err   <= w_reject;
      if (w_accept) begin
        r_row_len   <= row_len;
        r_row_base  <= row_base;
        r_w_base    <= w_base;
        r_fs        <= filter_size;
        r_out_count <= w_out_count;
      end
      // Data returns one cycle after issue: mark which reads feed taps and which feed A
      r_wcap_en  <= r_rd_en && (r_state == S_LOAD_W);
      r_wcap_idx <= r_cnt[2:0];
      r_ra_en    <= r_rd_en && (r_state == S_STREAM);
      r_cur_a    <= r_ra_en ? mem_rd_data : '0;
      r_a_valid  <= r_ra_en;
      for (int unsigned k = 0; k < MAX_TAPS; k++) begin
        if (w_accept && (3'(k) >= filter_size)) r_tap[k] <= '0;
        else if (r_wcap_en && (r_wcap_idx == 3'(k))) r_tap[k] <= mem_rd_data;
      end
    end
  end

  assign mem_rd_en   = r_rd_en;
  assign mem_rd_addr = r_rd_addr;
  assign current_a   = r_cur_a;
  assign a_valid     = r_a_valid;
  assign current_b1  = r_tap[0];
  assign current_b2  = r_tap[1];
  assign current_b3  = r_tap[2];
  assign current_b4  = r_tap[3];
  assign current_b5  = r_tap[4];
  assign array_rst_n = r_arr_rst_n;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;
  assign out_count   = r_out_count;

endmodule
